// File: rtl/demux8_seq_ctrl.sv
// Address sequencer for the EGO1 8-way demux: steps sel on a prescaler tick (RUN)
// or a button press (PAUSED). Define DEMUX8_SEQ_DEBOUNCE_EN to include the button debouncer.
module demux8_seq_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       step_btn,
  input  logic       d_in,
  output logic [2:0] sel,
  output logic       d_out,
  output logic       step_pulse,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sel_q, sel_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic          d_out_q, d_out_d;

  // Button path: 2-FF synchronizer, optional debouncer, rising-edge detect.
  logic sync1_q, sync2_q, btn_lvl, btn_prev_q, btn_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      sync1_q    <= step_btn;
      sync2_q    <= sync1_q;
      btn_prev_q <= btn_lvl;
    end
  end

`ifdef DEMUX8_SEQ_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DB_CYCLES);
  logic [DW-1:0] db_cnt_q;
  logic          db_lvl_q;

  // Level is accepted on the DB_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else if (sync2_q == db_lvl_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_lvl_q <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign btn_lvl = db_lvl_q;
`else
  assign btn_lvl = sync2_q;
`endif

  assign btn_rise = btn_lvl & ~btn_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sel_q   <= 3'd0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      d_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      d_out_q <= d_out_d;
    end
  end

  logic       tick, btn_step, do_step;
  logic [2:0] nxt_sel;
  logic       nxt_dir, nxt_wrap;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick     = 1'b0;
    nxt_sel  = sel_q;
    nxt_dir  = dir_q;
    nxt_wrap = 1'b0;

    case (state_q)
      S_IDLE:   if (en)  state_d = S_RUN;
      S_RUN:    if (!en) state_d = S_PAUSED;
      S_PAUSED: if (en)  state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase

    // A state change clears the prescaler, so a pause on a tick cycle takes no step.
    if (state_d != state_q || state_q != S_RUN || mode == M_HOLD) begin
      presc_d = '0;
    end else if (presc_q == PW'(TICK_DIV - 1)) begin
      presc_d = '0;
      tick    = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    btn_step = btn_rise && state_q == S_PAUSED && state_d == S_PAUSED;
    do_step  = (tick || btn_step) && mode != M_HOLD;

    case (mode)
      M_UP: begin
        nxt_sel  = sel_q + 3'd1;
        nxt_wrap = (sel_q == 3'd7);
      end
      M_DOWN: begin
        nxt_sel  = sel_q - 3'd1;
        nxt_wrap = (sel_q == 3'd0);
      end
      M_PP: begin
        if (dir_q == DIR_UP) begin
          if (sel_q == 3'd7) begin
            nxt_sel  = 3'd6;
            nxt_dir  = DIR_DN;
            nxt_wrap = 1'b1;
          end else begin
            nxt_sel = sel_q + 3'd1;
          end
        end else begin
          if (sel_q == 3'd0) begin
            nxt_sel  = 3'd1;
            nxt_dir  = DIR_UP;
            nxt_wrap = 1'b1;
          end else begin
            nxt_sel = sel_q - 3'd1;
          end
        end
      end
      default: ;
    endcase

    sel_d   = do_step ? nxt_sel : sel_q;
    dir_d   = do_step ? nxt_dir : dir_q;
    step_d  = do_step;
    wrap_d  = do_step & nxt_wrap;
    d_out_d = (state_d != S_IDLE) & d_in;
  end

  assign sel        = sel_q;
  assign d_out      = d_out_q;
  assign step_pulse = step_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_demux8_seq_ctrl.sv
// Directed bench for demux8_seq_ctrl with TICK_DIV=4, DB_CYCLES=4; button latency
// expectations follow whether DEMUX8_SEQ_DEBOUNCE_EN is defined.
module tb_demux8_seq_ctrl;

`ifdef DEMUX8_SEQ_DEBOUNCE_EN
  localparam int BTN_LAT      = 7;
  localparam int GLITCH_STEPS = 0;
`else
  localparam int BTN_LAT      = 3;
  localparam int GLITCH_STEPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, step_btn, d_in;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       d_out, step_pulse, wrap;

  int errors = 0;
  int checks = 0;
  int exp_sel;

  demux8_seq_ctrl #(.TICK_DIV(4), .DB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step_btn(step_btn),
    .d_in(d_in), .sel(sel), .d_out(d_out), .step_pulse(step_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; step_btn = 1'b0; d_in = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({sel, d_out, step_pulse, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL reset_vals sel=%0d d_out=%b sp=%b wrap=%b exp all 0", sel, d_out, step_pulse, wrap);
    end
    rst_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({sel, d_out, step_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL idle_hold sel=%0d d_out=%b sp=%b exp 0/0/0", sel, d_out, step_pulse);
    end
  endtask

  task automatic test_up();
    en = 1'b1;
    cyc();
    exp_sel = 0;
    checks++;
    if ({sel, step_pulse} !== 4'b0) begin
      errors++;
      $display("FAIL run_entry sel=%0d sp=%b exp 0/0", sel, step_pulse);
    end
    for (int k = 1; k <= 8; k++) begin
      repeat (3) begin
        cyc();
        checks++;
        if (step_pulse !== 1'b0 || sel !== 3'(exp_sel)) begin
          errors++;
          $display("FAIL up_gap sel=%0d sp=%b exp %0d/0", sel, step_pulse, exp_sel);
        end
      end
      cyc();
      exp_sel = (exp_sel + 1) & 7;
      checks++;
      if ({sel, step_pulse, wrap} !== {3'(exp_sel), 1'b1, (k == 8)}) begin
        errors++;
        $display("FAIL up_step k=%0d sel=%0d sp=%b wrap=%b exp %0d/1/%b", k, sel, step_pulse, wrap, exp_sel, k == 8);
      end
    end
    checks++;
    if (d_out !== 1'b1) begin
      errors++;
      $display("FAIL run_dout d_out=%b exp 1", d_out);
    end
  endtask

  task automatic test_pingpong();
    int pp [24];
    pp = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4};
    mode = 2'b10;
    for (int i = 0; i < 24; i++) begin
      repeat (3) begin
        cyc();
        checks++;
        if (step_pulse !== 1'b0) begin
          errors++;
          $display("FAIL pp_gap i=%0d sp=%b exp 0", i, step_pulse);
        end
      end
      cyc();
      checks++;
      if ({sel, step_pulse, wrap} !== {3'(pp[i]), 1'b1, (i == 7 || i == 14 || i == 21)}) begin
        errors++;
        $display("FAIL pp_step i=%0d sel=%0d sp=%b wrap=%b exp %0d/1/%b", i, sel, step_pulse, wrap,
                 pp[i], (i == 7 || i == 14 || i == 21));
      end
    end
    mode = 2'b00;
    repeat (4) cyc();
    exp_sel = 5;
    checks++;
    if ({sel, step_pulse, wrap} !== {3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pp_to_up sel=%0d sp=%b wrap=%b exp 5/1/0", sel, step_pulse, wrap);
    end
  endtask

  task automatic test_pause_button();
    int n;
    mode = 2'b01;
    repeat (2) begin
      repeat (4) cyc();
      exp_sel = exp_sel - 1;
      checks++;
      if (sel !== 3'(exp_sel) || wrap !== 1'b0) begin
        errors++;
        $display("FAIL down_step sel=%0d wrap=%b exp %0d/0", sel, wrap, exp_sel);
      end
    end
    repeat (3) cyc();
    en = 1'b0;
    cyc();
    checks++;
    if ({sel, step_pulse} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL pause_on_tick sel=%0d sp=%b exp 3/0", sel, step_pulse);
    end
    mode = 2'b00;
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      checks++;
      if (sel !== ((k >= BTN_LAT) ? 3'd4 : 3'd3) || step_pulse !== (k == BTN_LAT)) begin
        errors++;
        $display("FAIL press k=%0d sel=%0d sp=%b exp %0d/%b", k, sel, step_pulse,
                 (k >= BTN_LAT) ? 4 : 3, k == BTN_LAT);
      end
      if (k == 10) step_btn = 1'b0;
    end
    exp_sel = 4;
    n = 0;
    step_btn = 1'b1;
    cyc(); n += int'(step_pulse);
    cyc(); n += int'(step_pulse);
    step_btn = 1'b0;
    repeat (15) begin
      cyc();
      n += int'(step_pulse);
    end
    exp_sel = exp_sel + GLITCH_STEPS;
    checks++;
    if (n !== GLITCH_STEPS || sel !== 3'(exp_sel)) begin
      errors++;
      $display("FAIL glitch steps=%0d sel=%0d exp %0d/%0d", n, sel, GLITCH_STEPS, exp_sel);
    end
  endtask

  task automatic test_run_ignores_btn();
    logic exp_sp;
    en = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      exp_sp = (k >= 5) && ((k - 5) % 4 == 0);
      if (exp_sp) exp_sel = (exp_sel + 1) & 7;
      checks++;
      if (sel !== 3'(exp_sel) || step_pulse !== exp_sp) begin
        errors++;
        $display("FAIL run_btn k=%0d sel=%0d sp=%b exp %0d/%b", k, sel, step_pulse, exp_sel, exp_sp);
      end
      if (k == 12) step_btn = 1'b0;
    end
  endtask

  task automatic test_hold();
    logic [11:0] pat;
    pat = 12'b1011_0011_1010;
    mode = 2'b11;
    for (int k = 0; k < 12; k++) begin
      d_in = pat[k];
      cyc();
      checks++;
      if (sel !== 3'(exp_sel) || step_pulse !== 1'b0 || wrap !== 1'b0 || d_out !== pat[k]) begin
        errors++;
        $display("FAIL hold k=%0d sel=%0d sp=%b wrap=%b d_out=%b exp %0d/0/0/%b", k, sel, step_pulse,
                 wrap, d_out, exp_sel, pat[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 2'b00;
    d_in = 1'b1;
    n = (5 - exp_sel) & 7;
    repeat (n * 4) cyc();
    checks++;
    if ({sel, step_pulse, d_out} !== {3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset sel=%0d sp=%b d_out=%b exp 5/1/1", sel, step_pulse, d_out);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, d_out, step_pulse, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset sel=%0d d_out=%b sp=%b wrap=%b exp all 0", sel, d_out, step_pulse, wrap);
    end
    en = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (6) cyc();
    checks++;
    if ({sel, d_out, step_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle sel=%0d d_out=%b sp=%b exp 0/0/0", sel, d_out, step_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_pingpong();
    test_pause_button();
    test_run_ignores_btn();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
